// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL definitions for the SRAM responder.
//   - bus widths (TL_AW, TL_DW, ...)
//   - A/D opcode enums
//   - tl_h2d_t / tl_d2h_t channel structs
//   - rsp_entry_t response-queue entry
//   - tl_mask_ok(): byte-mask legality check for a request
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int AgeW   = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // a_opcode is a plain vector so that unsupported encodings can be carried
  // and reported as errors.
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    tl_d_op_e          d_opcode;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic [AgeW-1:0]   age;
  } rsp_entry_t;

  // The legal byte lanes of an access are the 1<<size bytes starting at
  // addr_lo. A full write must enable exactly those lanes; reads and
  // partial writes may enable any subset of them. Sizes above a word have
  // no legal lanes.
  function automatic logic tl_mask_ok(input logic [TL_SZW-1:0] size,
                                      input logic [1:0]        addr_lo,
                                      input logic [TL_DBW-1:0] mask,
                                      input logic              full);
    logic [TL_DBW-1:0] span;
    case (size)
      2'd0:    span = 4'b0001 << addr_lo;
      2'd1:    span = 4'b0011 << addr_lo;
      2'd2:    span = 4'b1111;
      default: span = 4'b0000;
    endcase
    if (full) begin
      tl_mask_ok = (span != '0) && (mask == span);
    end else begin
      tl_mask_ok = (span != '0) && ((mask & ~span) == '0);
    end
  endfunction

endpackage

// File: rtl/tlul_sram_responder_if.sv
// tlul_sram_responder_if: TL-UL host/device channel bundle.
//   tl_i : host -> device (A channel + d_ready)
//   tl_o : device -> host (D channel + a_ready)
// Modports: master (host side), slave (device side).
interface tlul_sram_responder_if;
  import tlul_pkg::*;

  tl_h2d_t tl_i;
  tl_d2h_t tl_o;

  modport master (output tl_i, input tl_o);
  modport slave  (input tl_i, output tl_o);

endinterface

// File: rtl/tlul_rsp_fifo.sv
// tlul_rsp_fifo: in-order response queue with a per-entry age counter.
//   clk, reset : clock, asynchronous active-high reset (control state only)
//   push       : write push_data at the tail (caller guarantees !full)
//   push_data  : entry to enqueue; its age field is the starting age
//   pop        : drop the head (caller guarantees head is presentable)
//   full/empty : occupancy flags
//   head       : head entry, age field reflecting the live counter
// Every age counter advances each cycle and saturates at Latency.
module tlul_rsp_fifo
  import tlul_pkg::*;
#(
  parameter int Depth   = 2,
  parameter int Latency = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rsp_entry_t push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output rsp_entry_t head
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [AgeW-1:0] LatAge   = AgeW'(Latency);

  rsp_entry_t      slot  [Depth];
  logic [AgeW-1:0] age_q [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] count;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    ptr_inc = (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  always_comb begin
    head     = slot[rptr];
    head.age = age_q[rptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) age_q[i] <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < Depth; i++) begin
        if (push && (wptr == PtrW'(i))) begin
          age_q[i] <= push_data.age;
        end else if (age_q[i] < LatAge) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Payload storage carries no reset; only occupied slots are ever observed.
  always_ff @(posedge clk) begin
    if (push) slot[wptr] <= push_data;
  end

endmodule

// File: rtl/tlul_sram_responder.sv
// tlul_sram_responder: TL-UL device that serves Get/PutFullData/
// PutPartialData from a word-addressed internal memory and returns one
// in-order D response per request after at least Latency cycles.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   tl     : slave modport; tl.tl_i = A channel + d_ready,
//            tl.tl_o = D channel + a_ready
//   busy_o : response queue non-empty
module tlul_sram_responder
  import tlul_pkg::*;
#(
  parameter int          MemWords = 256,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int          RspDepth = 2,
  parameter int          Latency  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  tlul_sram_responder_if.slave  tl,
  output logic                  busy_o
);

  localparam int IdxW = $clog2(MemWords);
  localparam int AW1  = TL_AW + 1;
  localparam logic [TL_AW:0] LoAddr = {1'b0, BaseAddr};
  localparam logic [TL_AW:0] HiAddr = LoAddr + (AW1'(MemWords) << 2);
  localparam logic [AgeW-1:0] LatAge = AgeW'(Latency);

  logic [TL_DW-1:0] mem [MemWords];

  tl_h2d_t         a;
  logic [TL_AW:0]  addr_ext;
  logic [IdxW-1:0] idx;
  logic            in_range, size_ok, align_ok, op_ok, mask_ok;
  logic            is_get, is_put, req_err, accept;
  logic            full, empty, d_valid, pop;
  rsp_entry_t      push_entry, head;

  assign a        = tl.tl_i;
  assign addr_ext = {1'b0, a.a_address};
  // BaseAddr is aligned to the memory span, so the low address bits are
  // already the word offset.
  assign idx      = a.a_address[IdxW+1:2];

  assign in_range = (addr_ext >= LoAddr) && (addr_ext < HiAddr);
  assign size_ok  = (a.a_size <= 2'd2);
  assign is_get   = (a.a_opcode == Get);
  assign is_put   = (a.a_opcode == PutFullData) || (a.a_opcode == PutPartialData);
  assign op_ok    = is_get || is_put;
  assign mask_ok  = tl_mask_ok(a.a_size, a.a_address[1:0], a.a_mask,
                               a.a_opcode == PutFullData);

  always_comb begin
    case (a.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~a.a_address[0];
      2'd2:    align_ok = (a.a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  assign req_err = !(in_range && size_ok && align_ok && op_ok && mask_ok);
  assign accept  = a.a_valid && !full;

  // Acceptance stage: classify, access memory, build the response entry.
  // The acceptance cycle counts as the first cycle of latency.
  always_comb begin
    push_entry          = '0;
    push_entry.d_opcode = is_get ? AccessAckData : AccessAck;
    push_entry.d_size   = a.a_size;
    push_entry.d_source = a.a_source;
    push_entry.d_data   = (is_get && !req_err) ? mem[idx] : '0;
    push_entry.d_error  = req_err;
    push_entry.age      = AgeW'(1);
  end

  always_ff @(posedge clk) begin
    if (accept && is_put && !req_err) begin
      for (int b = 0; b < TL_DBW; b++) begin
        if (a.a_mask[b]) mem[idx][8*b +: 8] <= a.a_data[8*b +: 8];
      end
    end
  end

  tlul_rsp_fifo #(
    .Depth   (RspDepth),
    .Latency (Latency)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Response stage: the head is presented once it has aged Latency cycles
  // and is held until the host takes it.
  assign d_valid = !empty && (head.age == LatAge);
  assign pop     = d_valid && a.d_ready;
  assign busy_o  = !empty;

  always_comb begin
    tl.tl_o         = '0;
    tl.tl_o.a_ready = !full;
    tl.tl_o.d_valid = d_valid;
    if (d_valid) begin
      tl.tl_o.d_opcode = head.d_opcode;
      tl.tl_o.d_size   = head.d_size;
      tl.tl_o.d_source = head.d_source;
      tl.tl_o.d_data   = head.d_data;
      tl.tl_o.d_error  = head.d_error;
    end
  end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// tb_tlul_sram_responder: scoreboard bench for tlul_sram_responder.
// u_dut (Latency 1, depth 2) is driven by directed and random requests;
// each accepted request pushes its expected response from a byte-level
// memory model, and a monitor pops and compares every D handshake.
// u_lat (Latency 3, depth 4, BaseAddr 0x1000) covers latency and hold.
module tb_tlul_sram_responder;
  import tlul_pkg::*;

  localparam int          Words  = 256;
  localparam logic [31:0] Base   = 32'h0;
  localparam logic [2:0]  OP_PF  = 3'h0;
  localparam logic [2:0]  OP_PP  = 3'h1;
  localparam logic [2:0]  OP_GET = 3'h4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tlul_sram_responder_if bus ();
  tlul_sram_responder_if bus2 ();
  logic busy, busy2;

  tl_h2d_t h1 = '0;
  tl_h2d_t h2 = '0;
  logic    d_rdy = 1'b1;
  int      rdy_mode = 1;   // 0 low, 1 high, 2 random

  assign bus.tl_i  = {h1[$bits(tl_h2d_t)-1:1], d_rdy};
  assign bus2.tl_i = h2;

  tlul_sram_responder #(.MemWords(Words), .BaseAddr(Base), .RspDepth(2), .Latency(1)) u_dut (
    .clk(clk), .reset(reset), .tl(bus), .busy_o(busy));

  tlul_sram_responder #(.MemWords(16), .BaseAddr(32'h1000), .RspDepth(4), .Latency(3)) u_lat (
    .clk(clk), .reset(reset), .tl(bus2), .busy_o(busy2));

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [Words];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endfunction

  function automatic logic [49:0] d_fields(tl_d2h_t t);
    return {t.d_opcode, t.d_size, t.d_source, t.d_data, t.d_error, t.d_param, t.d_sink};
  endfunction

  always @(posedge clk) begin
    #1;
    d_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Reference model: decides the outcome of a request from the access rules
  // and applies writes byte by byte.
  task automatic model_push(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                            input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] src);
    exp_t   e;
    bit     err = 0;
    int     nb, lo, sp;
    longint a = longint'(ad);
    if (a < longint'(Base) || a >= longint'(Base) + Words * 4) err = 1;
    if (sz > 2) err = 1;
    else begin
      nb = 1 << sz;
      lo = int'(ad % 4);
      if (ad % nb != 0) err = 1;
      sp = ((1 << nb) - 1) << lo;
      if (op == OP_PF && int'(mk) != sp) err = 1;
      if ((op == OP_GET || op == OP_PP) && (int'(mk) & ~sp) != 0) err = 1;
    end
    if (op != OP_GET && op != OP_PF && op != OP_PP) err = 1;
    e.op = (op == OP_GET) ? 3'd1 : 3'd0;
    e.size = sz;
    e.src = src;
    e.err = err;
    e.data = '0;
    if (!err) begin
      int w;
      w = int'((a - longint'(Base)) / 4);
      if (op == OP_GET) e.data = ref_mem[w];
      else for (int b = 0; b < 4; b++) if (mk[b]) ref_mem[w][8*b +: 8] = dt[8*b +: 8];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares each D handshake with the scoreboard head and checks
  // that a stalled response does not change.
  tl_d2h_t prev;
  bit      pend = 0;
  bit      mark_pop = 0;
  int      first_pop_cyc = -1;

  always @(negedge clk) begin
    if (reset) pend = 0;
    else begin
      if (pend) begin
        chk("d_hold_valid", 64'(bus.tl_o.d_valid), 64'd1);
        chk("d_hold_fields", 64'(d_fields(bus.tl_o)), 64'(d_fields(prev)));
      end
      if (bus.tl_o.d_valid) begin
        if (d_rdy) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL d_unexpected: got response source %h, expected none", bus.tl_o.d_source);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("d_rsp", 64'(d_fields(bus.tl_o)), 64'({e.op, e.size, e.src, e.data, e.err, 3'b000, 1'b0}));
          end
          if (mark_pop) begin
            first_pop_cyc = cyc;
            mark_pop = 0;
          end
          pend = 0;
        end else begin
          pend = 1;
          prev = bus.tl_o;
        end
      end else pend = 0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] src,
                       output int acc);
    int g = 0;
    h1.a_valid = 1'b1; h1.a_opcode = op; h1.a_size = sz; h1.a_address = ad;
    h1.a_mask = mk; h1.a_data = dt; h1.a_source = src;
    @(negedge clk);
    while (!bus.tl_o.a_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    acc = -1;
    if (!bus.tl_o.a_ready) begin
      n_chk++;
      $display("FAIL a_accept_timeout: a_ready low for %0d cycles, expected 1", g);
    end else begin
      acc = cyc;
      model_push(op, sz, ad, mk, dt, src);
    end
    @(posedge clk);
    #1;
    h1.a_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(string nm);
    tl_d2h_t r;
    r = '0;
    r.a_ready = 1'b1;
    chk(nm, 64'({bus.tl_o, busy}), 64'({r, 1'b0}));
  endtask

  task automatic rand_req();
    logic [2:0] op; logic [1:0] sz; logic [31:0] ad; logic [3:0] mk, span;
    int r, word, sp, acc;
    r = $urandom_range(0, 99);
    if (r < 40) op = OP_GET;
    else if (r < 65) op = OP_PF;
    else if (r < 90) op = OP_PP;
    else begin
      r = $urandom_range(0, 4);
      op = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : (r == 2) ? 3'd5 : (r == 3) ? 3'd6 : 3'd7;
    end
    r = $urandom_range(0, 99);
    sz = (r < 65) ? 2'd2 : (r < 80) ? 2'd1 : (r < 95) ? 2'd0 : 2'd3;
    word = $urandom_range(0, Words - 1);
    r = $urandom_range(0, 99);
    if (r < 8) ad = 32'(Words * 4 + $urandom_range(0, 255) * 4);
    else if (r < 16 || sz == 2'd0) ad = 32'(word * 4 + $urandom_range(0, 3));
    else if (sz == 2'd1) ad = 32'(word * 4 + 2 * $urandom_range(0, 1));
    else ad = 32'(word * 4);
    sp = (sz <= 2'd2) ? (((1 << (1 << sz)) - 1) << ad[1:0]) : 15;
    span = sp[3:0];
    r = $urandom_range(0, 99);
    if (r < 12) mk = 4'($urandom_range(0, 15));
    else if (op == OP_PF) mk = span;
    else mk = span & 4'($urandom_range(0, 15));
    issue(op, sz, ad, mk, $urandom, 8'($urandom_range(0, 255)), acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc0, n, g;
    logic [49:0] held;

    h2.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst_during");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_rst("rst_after");
    @(posedge clk); #1;

    // Fill the model and the memory; back-to-back full-rate acceptance.
    acc0 = -1;
    for (int i = 0; i < Words; i++) begin
      issue(OP_PF, 2'd2, 32'(i * 4), 4'hF, $urandom, 8'(i), acc);
      if (i == 0) acc0 = acc;
    end
    chk("throughput", 64'(acc - acc0), 64'(Words - 1));
    drain();

    // Write then read, each response one cycle after acceptance.
    issue(OP_PF, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, acc);
    @(negedge clk);
    chk("lat1_put", 64'(bus.tl_o.d_valid), 64'd1);
    @(posedge clk); #1;
    issue(OP_GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd4, acc);
    @(negedge clk);
    chk("lat1_get", 64'({bus.tl_o.d_valid, bus.tl_o.d_data}), 64'({1'b1, 32'hDEADBEEF}));
    @(posedge clk); #1;
    issue(OP_PP, 2'd2, 32'h10, 4'h2, 32'h0000AA00, 8'd5, acc);
    issue(OP_GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd6, acc);
    // Error cases.
    issue(OP_GET, 2'd2, 32'(Words * 4), 4'hF, 32'h0, 8'd7, acc);
    issue(OP_PF, 2'd2, 32'h12, 4'hF, 32'h11111111, 8'd8, acc);
    issue(3'd3, 2'd2, 32'h20, 4'hF, 32'h22222222, 8'd9, acc);
    issue(OP_GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd10, acc);
    drain();

    // Backpressure with a full queue.
    set_rdy(0);
    issue(OP_GET, 2'd2, 32'h20, 4'hF, 32'h0, 8'd0, acc);
    issue(OP_GET, 2'd2, 32'h24, 4'hF, 32'h0, 8'd1, acc);
    @(negedge clk);
    chk("a_ready_full", 64'({bus.tl_o.a_ready, busy}), 64'({1'b0, 1'b1}));
    @(posedge clk); #1;
    fork
      issue(OP_GET, 2'd2, 32'h28, 4'hF, 32'h0, 8'd2, acc);
      begin
        repeat (3) @(posedge clk);
        #1;
        mark_pop = 1;
        rdy_mode = 1;
      end
    join
    chk("bp_accept_after_pop", 64'(acc), 64'(first_pop_cyc + 1));
    drain();

    // Reset with queued responses.
    set_rdy(0);
    issue(OP_GET, 2'd2, 32'h30, 4'hF, 32'h0, 8'd11, acc);
    issue(OP_GET, 2'd2, 32'h34, 4'hF, 32'h0, 8'd12, acc);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_rst("rst_mid");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_rst("rst_mid_after");
    @(posedge clk); #1;
    set_rdy(1);
    issue(OP_GET, 2'd2, 32'h10, 4'hF, 32'h0, 8'd13, acc);
    drain();

    // Latency 3 instance.
    h2 = '{a_valid: 1'b1, a_opcode: OP_PF, a_size: 2'd2, a_source: 8'd5, a_address: 32'h1004,
           a_mask: 4'hF, a_data: 32'h12345678, d_ready: 1'b1};
    @(negedge clk);
    n = cyc;
    @(posedge clk); #1 h2.a_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus2.tl_o.d_valid && g < 20) begin @(negedge clk); g++; end
    chk("lat3_put", 64'({cyc - n, bus2.tl_o.d_opcode, bus2.tl_o.d_error}), 64'({32'd3, AccessAck, 1'b0}));
    @(posedge clk); #1;
    h2.d_ready = 1'b0;
    h2.a_valid = 1'b1; h2.a_opcode = OP_GET; h2.a_source = 8'd6;
    @(negedge clk);
    @(posedge clk); #1 h2.a_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat3_valid_rise", 64'(bus2.tl_o.d_valid), 64'(k == 3));
    end
    held = d_fields(bus2.tl_o);
    chk("lat3_get", 64'(held), 64'({AccessAckData, 2'd2, 8'd6, 32'h12345678, 1'b0, 3'b000, 1'b0}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lat3_hold", 64'({bus2.tl_o.d_valid, d_fields(bus2.tl_o)}), 64'({1'b1, held}));
    end
    @(posedge clk); #1 h2.d_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat3_popped", 64'({bus2.tl_o.d_valid, busy2}), 64'd0);
    // Just below the base address.
    @(posedge clk); #1;
    h2.a_valid = 1'b1; h2.a_address = 32'h0FFC; h2.a_source = 8'd7;
    @(negedge clk);
    @(posedge clk); #1 h2.a_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus2.tl_o.d_valid && g < 20) begin @(negedge clk); g++; end
    chk("lat3_below_base", 64'({bus2.tl_o.d_valid, bus2.tl_o.d_error, bus2.tl_o.d_data}),
        64'({1'b1, 1'b1, 32'h0}));
    @(posedge clk); #1;

    // Randomized traffic under random backpressure.
    set_rdy(2);
    for (int i = 0; i < 400; i++) rand_req();
    set_rdy(1);
    drain();
    @(negedge clk);
    chk("sb_empty", 64'({exp_q.size(), busy}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlul_sram_responder.md
# tlul_sram_responder

TL-UL device-side responder that terminates the downstream port of the IOPMP request handler. It accepts A-channel requests on one `tl_h2d_t` port and serves them from a word-addressed internal memory. Each request gets exactly one D-channel response on one `tl_d2h_t` port, delivered in order through a bounded response queue with a programmable minimum latency. It is instantiated once per IOPMP channel as the slave model in the request-handler bench and as a scratch SRAM in integration builds.

## Interface
Parameters:
- `MemWords`, 256: 32-bit words of storage; power of two, ≥ 4.
- `BaseAddr`, 32'h0000_0000: byte address of word 0; aligned to `MemWords*4`.
- `RspDepth`, 2: response queue entries (outstanding requests); ≥ 1.
- `Latency`, 1: minimum cycles from A acceptance to D valid; 1..15.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tl_i`  in  `tl_h2d_t`  A channel (`a_valid`, opcode, size, source, address, mask, data) plus `d_ready`.
- `tl_o`  out  `tl_d2h_t`  D channel (`d_valid`, opcode, param, size, source, sink, data, error) plus `a_ready`.
- `busy_o`  out  1  queue non-empty.

## Operation
- Accept on `a_valid && a_ready`. `a_ready = !queue_full`, combinational from state only, never from `a_valid`.
- Each accepted request is classified in the acceptance cycle:
  - Error if the address is outside `[BaseAddr, BaseAddr + MemWords*4)`.
  - Error if `a_size > 2`.
  - Error if the address is not aligned to `1<<a_size`.
  - Error if the opcode is not Get, PutFullData or PutPartialData.
  - Error if a PutFullData mask does not exactly cover the size/offset bytes.
  - Error if a Get/PutPartialData mask has bits outside the size/offset bytes.
- Put without error: the memory word is written in the acceptance cycle, byte-enabled by `a_mask`.
- Get without error: the word is read in the acceptance cycle. Read-after-write across back-to-back requests returns the new data.
- Errored requests never modify memory.
- Queue entry fields: `d_opcode` (AccessAckData=1 for Get, AccessAck=0 otherwise, including errored unsupported opcodes), `d_size=a_size`, `d_source=a_source`, `d_data` (read word; 0 for Put or error), `d_error`, and a 4-bit age counter.
- `d_param=0` and `d_sink=0` always.
- Every entry's age increments each cycle, saturating at `Latency`.
- `d_valid` is set when the queue is non-empty and the head age equals `Latency`. The head pops on `d_valid && d_ready`.
- Once `d_valid` is asserted, it and all D fields hold stable until the handshake.
- Simultaneous pop and push when full: `a_ready` stays 0 that cycle. No bypass; the freed slot is visible next cycle.
- Push and pop on a non-full queue in the same cycle: occupancy is unchanged.

## Timing
- Reset (async assert, sync-safe deassert): queue empty, pointers 0, `a_ready=1`, `d_valid=0`, `busy_o=0`, all D fields 0.
- Memory contents are not reset.
- Reset mid-transaction discards all queued responses. Memory writes already accepted persist.
- Latency: with `Latency=1` and the queue empty, A accepted at cycle N gives `d_valid` at cycle N+1.
- Throughput: one request per cycle when `d_ready` is held high and `RspDepth ≥ Latency+1`.
- Pointers are `$clog2(RspDepth)` bits wide and wrap at `RspDepth-1 → 0`. Full/empty are distinguished by a separate count of `$clog2(RspDepth+1)` bits.

## Structure
- The `rsp_entry_t` struct (`d_opcode`, `d_size`, `d_source`, `d_data`, `d_error`, `age`) and the helper function `tl_mask_ok(size, addr_lo, mask, full)` go in `tlul_pkg`.
- Opcode enums and `TL_DW`/`TL_AW` come from `tlul_pkg`/`top_pkg`.
- One sub-module: `tlul_rsp_fifo`, a parameterised synchronous FIFO of `rsp_entry_t` with per-entry age counters. The top holds the decode, mask check and memory array.

## Test plan
- Write then read: PutFullData addr 0x10, size 2, mask 0xF, data 0xDEADBEEF, source 3; then Get 0x10. Expect AccessAck source 3 `d_error=0`, then AccessAckData data 0xDEADBEEF, each 1 cycle after acceptance.
- Partial write: PutPartialData 0x10, mask 0x2, data 0x0000AA00 over 0xDEADBEEF, then Get. Expect 0xDEADAAEF.
- Errors:
  - Get at `BaseAddr + MemWords*4` gives AccessAckData with `d_error=1`, data 0.
  - PutFullData at 0x12 with size 2 gives AccessAck with `d_error=1`, and memory is unchanged.
  - Opcode 3 gives AccessAck with `d_error=1`.
- Backpressure: `RspDepth=2`, `d_ready=0`, issue 3 Gets. `a_ready` drops after the 2nd. Raise `d_ready`: responses arrive in order with sources 0, 1, 2 and the 3rd is accepted the cycle after the first pop.
- Latency: `Latency=3`, single Get at cycle N. `d_valid` first asserts at N+3; hold `d_ready=0` for 5 cycles and check the D fields stay stable.
- Reset mid-operation: two queued responses, assert `reset` for 1 cycle. Expect `d_valid=0`, `a_ready=1`, `busy_o=0`, and a prior write still readable.
